// File: rtl/datapath_ctrl.sv
// Sequencing controller for a load / rotate / multiply / write datapath with a valid/ready request port.
// Optional write counter output wr_count is built when DATAPATH_CTRL_WRCOUNT_EN is defined.
module datapath_ctrl #(
    parameter int NUM_W = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [NUM_W-1:0]      num,
    input  logic [NUM_W-1:0]      key,
    output logic [NUM_W-1:0]      num_q,
    output logic [NUM_W-1:0]      key_q,
    output logic                  reg_en,
    output logic                  rot_en,
    output logic                  mem_we,
    output logic [2**NUM_W-1:0]   mem_sel,
    output logic                  busy,
    output logic                  done,
`ifdef DATAPATH_CTRL_WRCOUNT_EN
    output logic [7:0]            wr_count,
`endif
    output logic [2:0]            dbg_state
);

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
    // req_ready is 1 only in IDLE, so requests presented while busy are dropped, never queued.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        ROT    = 3'd2,
        SETTLE = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam logic [2**NUM_W-1:0] SEL_ONE = {{(2**NUM_W-1){1'b0}}, 1'b1};

    state_t     state;
    logic [1:0] rot_cnt;

    assign dbg_state = state;

    // Outputs are registered alongside the state, so each strobe is set on the edge entering its state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            num_q     <= '0;
            key_q     <= '0;
            rot_cnt   <= 2'd0;
            reg_en    <= 1'b0;
            rot_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
`ifdef DATAPATH_CTRL_WRCOUNT_EN
            wr_count  <= 8'd0;
`endif
        end else begin
            reg_en  <= 1'b0;
            rot_en  <= 1'b0;
            mem_we  <= 1'b0;
            mem_sel <= '0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        num_q     <= num;
                        key_q     <= key;
                        state     <= LOAD;
                        reg_en    <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                LOAD: begin
                    rot_cnt <= key_q[1:0];
                    if (key_q[1:0] != 2'd0) begin
                        state  <= ROT;
                        rot_en <= 1'b1;
                    end else begin
                        state <= SETTLE;
                    end
                end
                ROT: begin
                    // rot_cnt counts the rotate cycles still owed, including this one.
                    rot_cnt <= rot_cnt - 2'd1;
                    if (rot_cnt == 2'd1) begin
                        state <= SETTLE;
                    end else begin
                        rot_en <= 1'b1;
                    end
                end
                SETTLE: begin
                    state   <= WRITE;
                    mem_we  <= 1'b1;
                    mem_sel <= SEL_ONE << num_q;
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
`ifdef DATAPATH_CTRL_WRCOUNT_EN
                    wr_count <= wr_count + 8'd1;
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    a_strobes_exclusive: assert property (@(posedge clock) disable iff (!reset_n)
        $onehot0({reg_en, rot_en, mem_we}));

    a_sel_only_on_write: assert property (@(posedge clock) disable iff (!reset_n)
        !mem_we |-> (mem_sel == '0));

    a_sel_onehot_on_write: assert property (@(posedge clock) disable iff (!reset_n)
        mem_we |-> $onehot(mem_sel));

endmodule

// File: tb/tb_datapath_ctrl.sv
// Scoreboard bench for datapath_ctrl: drivers push timed expected strobe events, a monitor pops and compares.
module tb_datapath_ctrl;

    localparam int EW = 32 + 4 + 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  num = 4'h0;
    logic [3:0]  key = 4'h0;
    logic [3:0]  num_q, key_q;
    logic        reg_en, rot_en, mem_we, busy, done;
    logic [15:0] mem_sel;
    logic [2:0]  dbg_state;
`ifdef DATAPATH_CTRL_WRCOUNT_EN
    logic [7:0]  wr_count;
`endif

    datapath_ctrl #(.NUM_W(4)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .num       (num),
        .key       (key),
        .num_q     (num_q),
        .key_q     (key_q),
        .reg_en    (reg_en),
        .rot_en    (rot_en),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .busy      (busy),
        .done      (done),
`ifdef DATAPATH_CTRL_WRCOUNT_EN
        .wr_count  (wr_count),
`endif
        .dbg_state (dbg_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail = 0;
    logic [EW-1:0] exp_q[$];
    logic [3:0] cap_num = 4'h0;
    logic [3:0] cap_key = 4'h0;
    int exp_writes = 0;

    localparam logic [3:0] K_REG  = 4'b0001;
    localparam logic [3:0] K_ROT  = 4'b0010;
    localparam logic [3:0] K_WE   = 4'b0100;
    localparam logic [3:0] K_DONE = 4'b1000;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Expected event schedule for an acceptance whose first cycle (LOAD) has cycle number acc.
    task automatic push_op(input int acc, input logic [3:0] k, input logic [15:0] sel);
        int r;
        r = int'(k[1:0]);
        exp_q.push_back({32'(acc), K_REG, 16'h0000});
        for (int i = 1; i <= r; i++) exp_q.push_back({32'(acc + i), K_ROT, 16'h0000});
        exp_q.push_back({32'(acc + 2 + r), K_WE, sel});
        exp_q.push_back({32'(acc + 3 + r), K_DONE, 16'h0000});
    endtask

    // driver: waits for req_ready, presents one request, records the expected response
    task automatic issue(input logic [3:0] n, input logic [3:0] k, input logic [15:0] sel,
                         input bit hold, output int acc);
        int t;
        t = 0;
        acc = -1;
        @(negedge clock); #1;
        while (!req_ready && t < 100) begin
            @(negedge clock); #1;
            t++;
        end
        if (!req_ready) begin
            fail_now("req_ready_wait");
            return;
        end
        num = n;
        key = k;
        req_valid = 1'b1;
        cap_num = n;
        cap_key = k;
        acc = cyc + 1;
        push_op(acc, k, sel);
        exp_writes++;
        @(posedge clock);
        if (!hold) begin
            @(negedge clock); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (exp_q.size() != 0) fail_now("queue_drain");
        repeat (2) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        cap_num = 4'h0;
        cap_key = 4'h0;
        exp_writes = 0;
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        logic [EW-1:0] got;
        logic [EW-1:0] e;
        if (reset_n) begin
            check("strobe_exclusive", 64'($countones({reg_en, rot_en, mem_we}) <= 1), 64'd1);
            if (!mem_we) check("mem_sel_idle", mem_sel, 16'h0000);
            check("ready_vs_busy", req_ready, !busy);
            check("num_q_hold", num_q, cap_num);
            check("key_q_hold", key_q, cap_key);
            if (reg_en || rot_en || mem_we || done) begin
                got = {32'(cyc), {done, mem_we, rot_en, reg_en}, mem_sel};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_event: got %0h expected none (cycle %0d)", got, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("event", got, e);
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  n;
        logic [3:0]  k;
        logic [15:0] sel;
    } vec_t;

    vec_t vecs[5] = '{
        '{4'h5, 4'h2, 16'h0020},
        '{4'h0, 4'h4, 16'h0001},
        '{4'hF, 4'h1, 16'h8000},
        '{4'hA, 4'h3, 16'h0400},
        '{4'h7, 4'h6, 16'h0080}
    };

    initial begin
        int acc;
        int last_acc;
        int t;

        // reset state
        repeat (2) @(negedge clock);
        check("rst_reg_en", reg_en, 1'b0);
        check("rst_rot_en", rot_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_sel", mem_sel, 16'h0000);
        check("rst_num_q", num_q, 4'h0);
        check("rst_key_q", key_q, 4'h0);
        #1;
        reset_n = 1'b1;
        @(negedge clock); #1;
        check("ready_after_rst", req_ready, 1'b1);

        // directed vectors, including the 0-rotate case
        foreach (vecs[i]) issue(vecs[i].n, vecs[i].k, vecs[i].sel, 1'b0, acc);
        drain();

        // operand changed and req_valid pulsed while busy: both ignored
        issue(4'h3, 4'h1, 16'h0008, 1'b0, acc);
        num = 4'hF;
        key = 4'h0;
        req_valid = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        req_valid = 1'b0;
        drain();

        // req_valid held high: acceptances every 8 cycles with key[1:0]=3
        last_acc = -1;
        for (int i = 0; i < 3; i++) begin
            issue(4'h9, 4'h3, 16'h0200, 1'b1, acc);
            if (last_acc >= 0) check("b2b_period", 64'(acc - last_acc), 64'd8);
            last_acc = acc;
        end
        @(negedge clock); #1;
        req_valid = 1'b0;
        drain();

        // reset during ROT aborts the operation
        issue(4'h6, 4'h3, 16'h0040, 1'b0, acc);
        t = 0;
        while (!rot_en && t < 10) begin
            @(negedge clock);
            t++;
        end
        if (!rot_en) fail_now("rot_wait");
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        cap_num = 4'h0;
        cap_key = 4'h0;
        exp_writes = 0;
        #1;
        check("abort_rot_en", rot_en, 1'b0);
        check("abort_reg_en", reg_en, 1'b0);
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_mem_sel", mem_sel, 16'h0000);
        check("abort_num_q", num_q, 4'h0);
        repeat (2) @(negedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        issue(4'hC, 4'h2, 16'h1000, 1'b0, acc);
        drain();

`ifdef DATAPATH_CTRL_WRCOUNT_EN
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic [3:0] nn;
            nn = 4'($urandom_range(0, 15));
            issue(nn, 4'h4, 16'h0001 << nn, 1'b0, acc);
        end
        drain();
        check("wr_count_wrap", wr_count, 8'd1);
        check("wr_count_model", wr_count, 8'(exp_writes));
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation bound expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 Parameter: NUM_W, default 4, width of num/key operands; decode width is 2**NUM_W.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 Port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port req_valid, input, 1, requester has an operation pending.
REQ-006 Port req_ready, output, 1, controller accepts a request this cycle.
REQ-007 Port num, input, NUM_W, operand; sampled on acceptance.
REQ-008 Port key, input, NUM_W, multiplier key; sampled on acceptance.
REQ-009 Port num_q / key_q, output, NUM_W each, captured operands driven to the datapath.
REQ-010 Port reg_en, output, 1, load strobe for the operand register.
REQ-011 Port rot_en, output, 1, one-position rotate strobe for the rotator.
REQ-012 Port mem_we, output, 1, memory write strobe.
REQ-013 Port mem_sel, output, 2**NUM_W, one-hot memory row select.
REQ-014 Port busy, output, 1, operation in progress (any state except IDLE).
REQ-015 Port done, output, 1, single-cycle completion pulse.

Function
REQ-016 FSM states: IDLE, LOAD, ROT, SETTLE, WRITE, DONE; encoding is implementation choice.
REQ-017 IDLE: req_ready=1; on req_valid=1 at the clock edge, capture num->num_q and key->key_q and go to LOAD.
REQ-018 req_ready is 1 only in IDLE; req_valid outside IDLE is ignored and never queued.
REQ-019 LOAD: reg_en=1 for exactly one cycle; load rot_cnt = key_q[1:0]; next ROT if rot_cnt!=0, else SETTLE.
REQ-020 ROT: rot_en=1 each cycle; rot_cnt decrements each cycle; leave for SETTLE in the cycle rot_cnt reaches 1 (exactly key_q[1:0] rot_en cycles, 0..3).
REQ-021 SETTLE: all strobes 0 for one cycle (combinational multiply settles).
REQ-022 WRITE: mem_we=1 and mem_sel = one-hot decode of num_q (bit num_q set) for exactly one cycle.
REQ-023 DONE: done=1 for one cycle; next state IDLE unconditionally.
REQ-024 mem_sel is all-zero whenever mem_we=0.
REQ-025 Latency: acceptance edge to done-high cycle = 4 + key[1:0] cycles; back-to-back issue period = 5 + key[1:0] cycles.
REQ-026 reg_en, rot_en and mem_we are mutually exclusive in every cycle.
REQ-027 num_q/key_q hold constant from capture until the next acceptance.

Reset
REQ-028 reset_n=0 asynchronously forces IDLE; num_q, key_q, rot_cnt = 0; reg_en, rot_en, mem_we, done, busy = 0; mem_sel = 0; req_ready = 1 while in IDLE after release.
REQ-029 Reset asserted mid-operation aborts it immediately; no further strobe and no done pulse for the aborted request.
REQ-030 First acceptance is possible at the first rising edge with reset_n=1.

Configuration
REQ-031 Macro DATAPATH_CTRL_WRCOUNT_EN: when defined, add output wr_count (8 bits), incremented in each WRITE cycle, wrapping 255->0, reset to 0; when undefined, the port and counter do not exist and behaviour is otherwise identical.

Verification
REQ-032 Reset then num=4'h5, key=4'h2, req_valid for 1 cycle -> reg_en at +1, rot_en at +2,+3, mem_we at +5 with mem_sel=16'h0020, done at +6.
REQ-033 key=4'h4 (key[1:0]=0) -> no rot_en cycles; mem_we at +3, done at +4.
REQ-034 req_valid held high continuously with key=4'h3 -> acceptances exactly 8 cycles apart; req_ready low while busy.
REQ-035 reset_n pulsed low during ROT -> all outputs 0 at once; no mem_we/done; a new request after release completes normally.
REQ-036 num changed to 4'hF during busy -> mem_sel still decodes the captured num; strobes never overlap (assertion over entire run).
REQ-037 With DATAPATH_CTRL_WRCOUNT_EN defined, 257 operations -> wr_count=1; without the macro, the same bench compiles without wr_count.
